// File: rtl/rv_id_stage_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation codes, writeback selects,
// and the decoded-control bundle passed from the ID decoder to the ID/EX register.
package rv_id_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    imm_fmt_e   imm_fmt;
    logic [3:0] alu;
    logic       src_a;
    logic       src_b;
    logic [2:0] funct3;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [1:0] wb_sel;
    logic       illegal;
  } ctrl_t;

  // alt selects SUB/SRA; callers only pass it where funct7[5] is meaningful.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
    logic [3:0] code;
    case (funct3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rv_id_stage_regfile.sv
// 32-entry register file: two combinational read ports, one write port,
// x0 hardwired to zero and write-through bypass from the WB port.
module rv_regfile
  import rv_id_stage_pkg::*;
#(
  parameter int BW_DATA = XLEN
) (
  input  logic               i_rf_clk,
  input  logic               i_rf_rst,
  input  logic [4:0]         i_rf_rs1,
  input  logic [4:0]         i_rf_rs2,
  output logic [BW_DATA-1:0] o_rf_rs1_data,
  output logic [BW_DATA-1:0] o_rf_rs2_data,
  input  logic               i_rf_we,
  input  logic [4:0]         i_rf_rd,
  input  logic [BW_DATA-1:0] i_rf_wdata
);

  logic [BW_DATA-1:0] mem [32];

  always_ff @(posedge i_rf_clk) begin
    if (i_rf_rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (i_rf_we && (i_rf_rd != 5'd0)) begin
      mem[i_rf_rd] <= i_rf_wdata;
    end
  end

  always_comb begin
    o_rf_rs1_data = '0;
    if (i_rf_rs1 != 5'd0) begin
      o_rf_rs1_data = (i_rf_we && (i_rf_rd == i_rf_rs1)) ? i_rf_wdata : mem[i_rf_rs1];
    end
  end

  always_comb begin
    o_rf_rs2_data = '0;
    if (i_rf_rs2 != 5'd0) begin
      o_rf_rs2_data = (i_rf_we && (i_rf_rd == i_rf_rs2)) ? i_rf_wdata : mem[i_rf_rs2];
    end
  end

endmodule

// File: rtl/rv_id_stage.sv
// RV32I decode stage: instruction decode, immediate generation, register read
// and the ID/EX pipeline register with bubble insertion on stall/flush.
module rv_id_stage
  import rv_id_stage_pkg::*;
#(
  parameter int BW_DATA = XLEN
) (
  input  logic               i_id_clk,
  input  logic               i_id_rst,
  input  logic               i_id_flush,
  input  logic               i_id_stall,
  input  logic [BW_DATA-1:0] i_id_pc,
  input  logic [31:0]        i_id_instr,
  input  logic               i_id_wb_we,
  input  logic [4:0]         i_id_wb_rd,
  input  logic [BW_DATA-1:0] i_id_wb_data,
  output logic [4:0]         o_id_rs1,
  output logic [4:0]         o_id_rs2,
  output logic [BW_DATA-1:0] o_id_ex_pc,
  output logic [BW_DATA-1:0] o_id_ex_rs1_data,
  output logic [BW_DATA-1:0] o_id_ex_rs2_data,
  output logic [BW_DATA-1:0] o_id_ex_imm,
  output logic [4:0]         o_id_ex_rs1,
  output logic [4:0]         o_id_ex_rs2,
  output logic [4:0]         o_id_ex_rd,
  output logic [3:0]         o_id_ex_alu_ctrl,
  output logic               o_id_ex_alu_src_a,
  output logic               o_id_ex_alu_src_b,
  output logic [2:0]         o_id_ex_funct3,
  output logic               o_id_ex_reg_we,
  output logic               o_id_ex_mem_re,
  output logic               o_id_ex_mem_we,
  output logic               o_id_ex_branch,
  output logic               o_id_ex_jal,
  output logic               o_id_ex_jalr,
  output logic [1:0]         o_id_ex_wb_sel,
  output logic               o_id_ex_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctrl_t      dec;
  logic       dec_ok;
  logic [31:0]        imm32;
  logic [BW_DATA-1:0] imm;
  logic [BW_DATA-1:0] rs1_data;
  logic [BW_DATA-1:0] rs2_data;
  logic               kill;

  assign opcode = i_id_instr[6:0];
  assign funct3 = i_id_instr[14:12];
  assign funct7 = i_id_instr[31:25];

  always_comb begin
    dec    = '0;
    dec_ok = 1'b1;
    case (opcode)
      OPC_LUI: begin
        dec.rd = i_id_instr[11:7]; dec.imm_fmt = IMM_U; dec.alu = ALU_PASS_B;
        dec.src_b = 1'b1; dec.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.rd = i_id_instr[11:7]; dec.imm_fmt = IMM_U; dec.alu = ALU_ADD;
        dec.src_a = 1'b1; dec.src_b = 1'b1; dec.reg_we = 1'b1;
      end
      OPC_JAL: begin
        dec.rd = i_id_instr[11:7]; dec.imm_fmt = IMM_J; dec.alu = ALU_ADD;
        dec.src_a = 1'b1; dec.src_b = 1'b1; dec.jal = 1'b1;
        dec.reg_we = 1'b1; dec.wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        dec_ok = (funct3 == 3'b000);
        dec.rs1 = i_id_instr[19:15]; dec.rd = i_id_instr[11:7]; dec.imm_fmt = IMM_I;
        dec.alu = ALU_ADD; dec.src_b = 1'b1; dec.jalr = 1'b1;
        dec.reg_we = 1'b1; dec.wb_sel = WB_PC4;
      end
      OPC_BRANCH: begin
        dec_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
        dec.rs1 = i_id_instr[19:15]; dec.rs2 = i_id_instr[24:20]; dec.imm_fmt = IMM_B;
        dec.alu = ALU_SUB; dec.branch = 1'b1; dec.funct3 = funct3;
      end
      OPC_LOAD: begin
        dec_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        dec.rs1 = i_id_instr[19:15]; dec.rd = i_id_instr[11:7]; dec.imm_fmt = IMM_I;
        dec.alu = ALU_ADD; dec.src_b = 1'b1; dec.mem_re = 1'b1;
        dec.reg_we = 1'b1; dec.wb_sel = WB_MEM; dec.funct3 = funct3;
      end
      OPC_STORE: begin
        dec_ok = (funct3[2] == 1'b0) && (funct3 != 3'b011);
        dec.rs1 = i_id_instr[19:15]; dec.rs2 = i_id_instr[24:20]; dec.imm_fmt = IMM_S;
        dec.alu = ALU_ADD; dec.src_b = 1'b1; dec.mem_we = 1'b1; dec.funct3 = funct3;
      end
      OPC_OP_IMM: begin
        // Only shifts carry funct7; for ADDI etc. bit 30 is ordinary immediate.
        if (funct3 == 3'b001) dec_ok = (funct7 == F7_BASE);
        else if (funct3 == 3'b101) dec_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        dec.rs1 = i_id_instr[19:15]; dec.rd = i_id_instr[11:7]; dec.imm_fmt = IMM_I;
        dec.alu = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
        dec.src_b = 1'b1; dec.reg_we = 1'b1;
      end
      OPC_OP: begin
        dec_ok = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec.rs1 = i_id_instr[19:15]; dec.rs2 = i_id_instr[24:20]; dec.rd = i_id_instr[11:7];
        dec.alu = alu_from_funct3(funct3, funct7[5]); dec.reg_we = 1'b1;
      end
      OPC_FENCE: ;
      default: dec_ok = 1'b0;
    endcase
    // The all-zero word is a fetch bubble, not an illegal instruction.
    if (!dec_ok) begin
      dec         = '0;
      dec.illegal = |i_id_instr;
    end
  end

  always_comb begin
    imm32 = 32'd0;
    case (dec.imm_fmt)
      IMM_I:   imm32 = {{20{i_id_instr[31]}}, i_id_instr[31:20]};
      IMM_S:   imm32 = {{20{i_id_instr[31]}}, i_id_instr[31:25], i_id_instr[11:7]};
      IMM_B:   imm32 = {{19{i_id_instr[31]}}, i_id_instr[31], i_id_instr[7],
                        i_id_instr[30:25], i_id_instr[11:8], 1'b0};
      IMM_U:   imm32 = {i_id_instr[31:12], 12'd0};
      IMM_J:   imm32 = {{11{i_id_instr[31]}}, i_id_instr[31], i_id_instr[19:12],
                        i_id_instr[20], i_id_instr[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm      = BW_DATA'($signed(imm32));
  assign o_id_rs1 = dec.rs1;
  assign o_id_rs2 = dec.rs2;

  rv_regfile #(.BW_DATA(BW_DATA)) u_regfile (
    .i_rf_clk      (i_id_clk),
    .i_rf_rst      (i_id_rst),
    .i_rf_rs1      (dec.rs1),
    .i_rf_rs2      (dec.rs2),
    .o_rf_rs1_data (rs1_data),
    .o_rf_rs2_data (rs2_data),
    .i_rf_we       (i_id_wb_we),
    .i_rf_rd       (i_id_wb_rd),
    .i_rf_wdata    (i_id_wb_data)
  );

  assign kill = i_id_rst || i_id_flush || i_id_stall;

  always_ff @(posedge i_id_clk) begin
    if (kill) begin
      o_id_ex_pc        <= '0;
      o_id_ex_rs1_data  <= '0;
      o_id_ex_rs2_data  <= '0;
      o_id_ex_imm       <= '0;
      o_id_ex_rs1       <= '0;
      o_id_ex_rs2       <= '0;
      o_id_ex_rd        <= '0;
      o_id_ex_alu_ctrl  <= '0;
      o_id_ex_alu_src_a <= 1'b0;
      o_id_ex_alu_src_b <= 1'b0;
      o_id_ex_funct3    <= '0;
      o_id_ex_reg_we    <= 1'b0;
      o_id_ex_mem_re    <= 1'b0;
      o_id_ex_mem_we    <= 1'b0;
      o_id_ex_branch    <= 1'b0;
      o_id_ex_jal       <= 1'b0;
      o_id_ex_jalr      <= 1'b0;
      o_id_ex_wb_sel    <= '0;
      o_id_ex_illegal   <= 1'b0;
    end else begin
      // PC travels with illegal/FENCE words so a trap can report it; bubbles carry 0.
      o_id_ex_pc        <= (|i_id_instr) ? i_id_pc : '0;
      o_id_ex_rs1_data  <= rs1_data;
      o_id_ex_rs2_data  <= rs2_data;
      o_id_ex_imm       <= imm;
      o_id_ex_rs1       <= dec.rs1;
      o_id_ex_rs2       <= dec.rs2;
      o_id_ex_rd        <= dec.rd;
      o_id_ex_alu_ctrl  <= dec.alu;
      o_id_ex_alu_src_a <= dec.src_a;
      o_id_ex_alu_src_b <= dec.src_b;
      o_id_ex_funct3    <= dec.funct3;
      o_id_ex_reg_we    <= dec.reg_we;
      o_id_ex_mem_re    <= dec.mem_re;
      o_id_ex_mem_we    <= dec.mem_we;
      o_id_ex_branch    <= dec.branch;
      o_id_ex_jal       <= dec.jal;
      o_id_ex_jalr      <= dec.jalr;
      o_id_ex_wb_sel    <= dec.wb_sel;
      o_id_ex_illegal   <= dec.illegal;
    end
  end

endmodule

// File: tb/tb_rv_id_stage.sv
// Self-checking bench for rv_id_stage: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_rv_id_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        sa;
    logic        sb;
    logic [2:0]  f3;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [1:0]  wb_sel;
    logic        illegal;
  } ex_t;

  logic clk = 1'b0;
  logic rst, flush, stall, wb_we;
  logic [31:0] pc, instr, wb_data;
  logic [4:0]  wb_rd;
  logic [4:0]  rs1, rs2;
  ex_t dut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_id_stage #(.BW_DATA(32)) u_dut (
    .i_id_clk          (clk),
    .i_id_rst          (rst),
    .i_id_flush        (flush),
    .i_id_stall        (stall),
    .i_id_pc           (pc),
    .i_id_instr        (instr),
    .i_id_wb_we        (wb_we),
    .i_id_wb_rd        (wb_rd),
    .i_id_wb_data      (wb_data),
    .o_id_rs1          (rs1),
    .o_id_rs2          (rs2),
    .o_id_ex_pc        (dut.pc),
    .o_id_ex_rs1_data  (dut.a),
    .o_id_ex_rs2_data  (dut.b),
    .o_id_ex_imm       (dut.imm),
    .o_id_ex_rs1       (dut.rs1),
    .o_id_ex_rs2       (dut.rs2),
    .o_id_ex_rd        (dut.rd),
    .o_id_ex_alu_ctrl  (dut.alu),
    .o_id_ex_alu_src_a (dut.sa),
    .o_id_ex_alu_src_b (dut.sb),
    .o_id_ex_funct3    (dut.f3),
    .o_id_ex_reg_we    (dut.reg_we),
    .o_id_ex_mem_re    (dut.mem_re),
    .o_id_ex_mem_we    (dut.mem_we),
    .o_id_ex_branch    (dut.branch),
    .o_id_ex_jal       (dut.jal),
    .o_id_ex_jalr      (dut.jalr),
    .o_id_ex_wb_sel    (dut.wb_sel),
    .o_id_ex_illegal   (dut.illegal)
  );

  // Reference: ISA-level decode of one word, register values filled in separately.
  function automatic ex_t decode_m(input logic [31:0] w, input logic [31:0] p);
    ex_t e;
    logic ok;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] f3tab [8];
    f3tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    e = '0; ok = 1'b1;
    case (op)
      7'h37: begin e.rd = w[11:7]; e.imm = {w[31:12], 12'd0}; e.alu = 10; e.sb = 1; e.reg_we = 1; end
      7'h17: begin e.rd = w[11:7]; e.imm = {w[31:12], 12'd0}; e.sa = 1; e.sb = 1; e.reg_we = 1; end
      7'h6F: begin
        e.rd = w[11:7]; e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        e.sa = 1; e.sb = 1; e.jal = 1; e.reg_we = 1; e.wb_sel = 2;
      end
      7'h67: begin
        ok = (f3 == 0); e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = {{20{w[31]}}, w[31:20]};
        e.sb = 1; e.jalr = 1; e.reg_we = 1; e.wb_sel = 2;
      end
      7'h63: begin
        ok = (f3 != 2) && (f3 != 3); e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        e.alu = 1; e.branch = 1; e.f3 = f3;
      end
      7'h03: begin
        ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = {{20{w[31]}}, w[31:20]};
        e.sb = 1; e.mem_re = 1; e.reg_we = 1; e.wb_sel = 1; e.f3 = f3;
      end
      7'h23: begin
        ok = (f3 <= 2); e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.imm = {{20{w[31]}}, w[31:25], w[11:7]}; e.sb = 1; e.mem_we = 1; e.f3 = f3;
      end
      7'h13: begin
        e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = {{20{w[31]}}, w[31:20]};
        e.sb = 1; e.reg_we = 1; e.alu = f3tab[f3];
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin ok = (f7 == 0) || (f7 == 7'h20); if (f7 == 7'h20) e.alu = 7; end
      end
      7'h33: begin
        e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.reg_we = 1; e.alu = f3tab[f3];
        if (f7 == 7'h20) begin ok = (f3 == 0) || (f3 == 5); e.alu = (f3 == 0) ? 4'd1 : 4'd7; end
        else ok = (f7 == 0);
      end
      7'h0F: ;
      default: ok = 1'b0;
    endcase
    if (!ok) begin e = '0; e.illegal = (w != 0); end
    e.pc = (w != 0) ? p : 32'd0;
    return e;
  endfunction

  logic [31:0] rf_m [32];
  ex_t exp_ex = '0;
  bit  model_valid = 0;

  function automatic logic [31:0] read_m(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_we && wb_rd == idx) return wb_data;
    return rf_m[idx];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_ex = '0;
      for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    end else begin
      if (flush || stall) exp_ex = '0;
      else begin
        exp_ex = decode_m(instr, pc);
        exp_ex.a = read_m(exp_ex.rs1);
        exp_ex.b = read_m(exp_ex.rs2);
      end
      if (wb_we && wb_rd != 0) rf_m[wb_rd] = wb_data;
    end
    model_valid = 1;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    ex_t d;
    if (model_valid) begin
      check("id_ex_bundle", dut, exp_ex);
      d = decode_m(instr, pc);
      check("hazard_rs", {rs1, rs2}, {d.rs1, d.rs2});
    end
  end

  task automatic step(input logic [31:0] w, input logic [31:0] p, input logic fl, input logic st,
                      input logic r, input logic we, input logic [4:0] rd, input logic [31:0] d);
    instr = w; pc = p; flush = fl; stall = st; rst = r;
    wb_we = we; wb_rd = rd; wb_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    logic [6:0]  ops [10];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
    instr = 0; pc = 0; flush = 0; stall = 0; rst = 1; wb_we = 0; wb_rd = 0; wb_data = 0;

    step(32'h0, 32'h0, 0, 0, 1, 0, 0, 0);
    step(32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    step(32'h0, 32'h4, 0, 0, 0, 0, 0, 0);
    check("reset_idle_zero", dut, 256'd0);

    step(32'h0, 32'h8, 0, 0, 0, 1, 5'd5, 32'h1234);
    step(32'hFFF28313, 32'h10, 0, 0, 0, 0, 0, 0);
    check("addi_rs1_data", dut.a, 32'h1234);
    check("addi_imm", dut.imm, 32'hFFFFFFFF);
    check("addi_ctrl", {dut.alu, dut.sb, dut.rd, dut.reg_we}, {4'd0, 1'b1, 5'd6, 1'b1});

    step(32'h0082A383, 32'h14, 0, 0, 0, 1, 5'd5, 32'h100);
    check("lw_bypass", dut.a, 32'h100);
    check("lw_ctrl", {dut.mem_re, dut.wb_sel, dut.imm}, {1'b1, 2'd1, 32'd8});

    step(32'hFE208EE3, 32'h40, 0, 0, 0, 0, 0, 0);
    check("beq_ctrl", {dut.branch, dut.alu, dut.reg_we}, {1'b1, 4'd1, 1'b0});
    check("beq_imm", dut.imm, 32'hFFFFFFFC);

    step(32'h00000093, 32'h44, 0, 0, 0, 1, 5'd0, 32'h5);
    check("x0_bypass_blocked", dut.a, 32'd0);
    step(32'h00000093, 32'h48, 0, 0, 0, 0, 0, 0);
    check("x0_stays_zero", dut.a, 32'd0);

    step(32'h002081B3, 32'h50, 0, 1, 0, 0, 0, 0);
    check("stall_bubble1", dut, 256'd0);
    step(32'h002081B3, 32'h50, 0, 1, 0, 0, 0, 0);
    check("stall_bubble2", dut, 256'd0);
    step(32'h002081B3, 32'h50, 0, 0, 0, 0, 0, 0);
    check("add_after_stall", {dut.reg_we, dut.rd, dut.alu, dut.pc}, {1'b1, 5'd3, 4'd0, 32'h50});
    step(32'h002081B3, 32'h54, 1, 1, 0, 0, 0, 0);
    check("flush_stall_bubble", dut, 256'd0);

    step(32'h0000007F, 32'h58, 0, 0, 0, 0, 0, 0);
    check("illegal_flag", dut.illegal, 1'b1);
    check("illegal_ctrl", {dut.reg_we, dut.mem_re, dut.mem_we, dut.branch, dut.jal, dut.jalr}, 6'd0);

    step(32'h002081B3, 32'h5C, 0, 0, 1, 0, 0, 0);
    check("rst_mid_stream", dut, 256'd0);

    for (int n = 0; n < 3000; n++) begin
      w = $urandom;
      case ($urandom_range(0, 11))
        10: ;
        11: w = 32'h0;
        default: begin
          w[6:0] = ops[$urandom_range(0, 9)];
          if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end
      endcase
      step(w, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 1) != 0,
           ($urandom_range(0, 2) == 0) ? w[19:15] : 5'($urandom_range(0, 31)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_id_stage.md
# rv_id_stage

Decode stage of the 5-stage RV32I pipeline. Sits directly downstream of the fetch stage and consumes its IF/ID register (PC and instruction word). It decodes the instruction, reads the 32×XLEN register file (written back from WB), and generates the immediate. It drives the ID/EX pipeline register consumed by the execute stage. It also exports source-register indices to the hazard unit and inserts bubbles on stall or flush.

## Interface
Parameters:
- BW_DATA, default `XLEN (32): datapath width.

Ports:
- i_id_clk  in  1  single clock; all state updates on rising edge.
- i_id_rst  in  1  reset, synchronous, active-high.
- i_id_flush  in  1  from EX: taken branch/jump; kill the instruction in ID.
- i_id_stall  in  1  from hazard unit: load-use stall; IF holds, ID inserts a bubble.
- i_id_pc  in  BW_DATA  PC from IF/ID.
- i_id_instr  in  32  instruction from IF/ID; 32'h0 is a bubble.
- i_id_wb_we  in  1  WB register write enable.
- i_id_wb_rd  in  5  WB destination index.
- i_id_wb_data  in  BW_DATA  WB write data.
- o_id_rs1, o_id_rs2  out  5  combinational source indices to hazard unit; 0 when the format has no such source.
- o_id_ex_pc  out  BW_DATA  registered PC.
- o_id_ex_rs1_data, o_id_ex_rs2_data  out  BW_DATA  registered operands.
- o_id_ex_imm  out  BW_DATA  registered sign-extended immediate.
- o_id_ex_rs1, o_id_ex_rs2, o_id_ex_rd  out  5  registered indices, for forwarding.
- o_id_ex_alu_ctrl  out  4  ALU operation code.
- o_id_ex_alu_src_a  out  1  0 = rs1, 1 = PC (AUIPC).
- o_id_ex_alu_src_b  out  1  0 = rs2, 1 = imm.
- o_id_ex_funct3  out  3  branch/load/store sub-op.
- o_id_ex_reg_we, o_id_ex_mem_re, o_id_ex_mem_we  out  1  control.
- o_id_ex_branch, o_id_ex_jal, o_id_ex_jalr  out  1  control-flow class.
- o_id_ex_wb_sel  out  2  0 = ALU, 1 = MEM, 2 = PC+4.
- o_id_ex_illegal  out  1  unsupported opcode/funct in a non-bubble instruction.

## Operation
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (treated as NOP).
- Any other opcode, or an invalid funct3/funct7 combination: decoded as a NOP with illegal=1.
- Immediate formats:
  - I: instr[31:20] sign-extended.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All formats sign-extend to BW_DATA.
- ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10.
  - LUI uses PASS_B.
  - AUIPC, loads, stores, JAL and JALR use ADD.
  - Branches use SUB; funct3 selects the comparison in EX.
- Register file:
  - x0 always reads 0 and writes to it are dropped.
  - A write occurs on the rising edge when wb_we=1 and wb_rd≠0.
  - Write-through bypass: when wb_we=1, wb_rd==rs and rs≠0, the read returns wb_data in the same cycle.
- ID/EX update priority (highest first): rst, flush, stall, normal.
  - rst: all ID/EX outputs 0 and every register-file entry cleared to 0.
  - flush or stall: a bubble is loaded. All control outputs (reg_we, mem_re, mem_we, branch, jal, jalr, illegal) are 0, and pc/imm/data/indices are 0.
  - normal: the decoded values are loaded.
- i_id_instr == 32'h0 decodes as a bubble with illegal=0.
- Register-file writes proceed regardless of flush/stall; they are blocked only by rst.

## Timing
- Latency is one cycle: inputs valid in cycle N appear on o_id_ex_* after edge N+1.
- o_id_rs1/o_id_rs2 are combinational from i_id_instr with zero latency, so the hazard unit can assert stall in the same cycle.
- Register-file write and decoder read of the same register in the same cycle: ID/EX captures the new value via the bypass.
- Stall held for K cycles: K consecutive bubbles. The held instruction is registered on the first cycle with stall=0.
- Flush and stall asserted together: treated as flush, which gives a bubble.
- Reset asserted mid-stream: all outputs read 0 on the following edge, whatever flush/stall is doing.
- Reset values: every o_id_ex_* output is 0. Outputs o_id_rs1/o_id_rs2 follow i_id_instr.

## Structure
- Shared header in common: opcode localparams, ALU code constants, and wb_sel codes. These are also used by the EX stage.
- Sub-module rv_regfile: 2 read ports and 1 write port, with x0 hardwiring and write-through bypass. Its ports are i_rf_clk and i_rf_rst.
- The decoder and the immediate generator are combinational inside rv_id_stage. The ID/EX registers are a single always block.

## Test plan
- Reset, then idle with instr=0 → all o_id_ex_* are 0 and illegal=0.
- WB writes x5=32'h1234 with we=1; next cycle `addi x6,x5,-1` (0xFFF28313) → after one edge: rs1_data=32'h1234, imm=32'hFFFFFFFF, alu_ctrl=ADD, alu_src_b=1, rd=6, reg_we=1.
- `lw x7,8(x5)` arrives in the same cycle that WB writes x5=32'h100 → rs1_data=32'h100 via bypass, mem_re=1, wb_sel=1, imm=8.
- `beq x1,x2,-4` (0xFE208EE3) → branch=1, imm=32'hFFFFFFFC, alu_ctrl=SUB, reg_we=0. Write x0=5 and read x0 → rs1_data reads 0.
- Valid `add` with stall=1 for 2 cycles, then stall=0 → two bubbles, then add registered. Same instruction with flush=1 and stall=1 → bubble.
- Opcode 7'b1111111 → illegal=1 and all other control 0. Assert rst during a valid instruction → outputs 0 next edge.
